// File: rtl/dcache_dm.sv
// Direct-mapped write-back data cache with 256-bit lines; hits complete combinationally.
// Optional macro DCACHE_WRITE_ALLOCATE_EN: store misses allocate instead of writing through.

module dcache_dm #(
   parameter int LINES = 32
) (
   input  logic         CLK,
   input  logic         RESET,
   input  logic [31:0]  data_address_2DC,
   input  logic         read_2DC,
   input  logic         write_2DC,
   input  logic [31:0]  data_write_2DC,
   input  logic [1:0]   data_write_size_2DC,
   input  logic         flush_2DC,
   output logic [31:0]  data_read_fDC,
   output logic         data_valid_fDC,
   output logic         flush_done,
   output logic [31:0]  data_address_2DM,
   output logic         MemWrite_2DM,
   output logic [31:0]  data_write_2DM,
   output logic [1:0]   data_write_size_2DM,
   output logic         MemRead_2DM,
   output logic         dBlkRead,
   input  logic [255:0] block_read_fDM,
   input  logic         block_read_fDM_valid,
   output logic         dBlkWrite,
   output logic [255:0] block_write_2DM,
   input  logic         block_write_fDM_valid
);

   localparam int IDX_W = $clog2(LINES);
   localparam int TAG_W = 27 - IDX_W;
`ifdef DCACHE_WRITE_ALLOCATE_EN
   localparam bit WRITE_ALLOC = 1'b1;
`else
   localparam bit WRITE_ALLOC = 1'b0;
`endif

   typedef enum logic [2:0] {
      IDLE,
      WB,
      REFILL,
      FL_SCAN,
      FL_WB
   } state_t;

   state_t             state_q, state_d;
   logic [LINES-1:0]   valid_q, valid_d;
   logic [LINES-1:0]   dirty_q, dirty_d;
   logic [TAG_W-1:0]   tag_q  [LINES];
   logic [TAG_W-1:0]   tag_d  [LINES];
   logic [255:0]       data_q [LINES];
   logic [255:0]       data_d [LINES];
   logic [26:0]        miss_line_q, miss_line_d;
   logic [IDX_W-1:0]   scan_idx_q, scan_idx_d;
   logic               scan_done_q, scan_done_d;

   logic [IDX_W-1:0]   req_idx, miss_idx;
   logic [TAG_W-1:0]   req_tag, miss_tag;
   logic               req_hit;
   logic [31:0]        hit_word, merged_word, shifted;
   logic [2:0]         st_off, st_len;

   assign req_idx     = data_address_2DC[5 +: IDX_W];
   assign req_tag     = data_address_2DC[31 -: TAG_W];
   assign miss_idx    = miss_line_q[IDX_W-1:0];
   assign miss_tag    = miss_line_q[26 -: TAG_W];
   assign req_hit     = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
   assign hit_word    = data_q[req_idx][{data_address_2DC[4:2], 5'b00000} +: 32];
   assign MemRead_2DM = 1'b0;

   // Big-endian lane merge: lane k is word bits [31-8k:24-8k], filled MSB first.
   always_comb begin
      merged_word = hit_word;
      shifted     = '0;
      st_off      = {1'b0, data_address_2DC[1:0]};
      st_len      = (data_write_size_2DC == 2'd0) ? 3'd4 : {1'b0, data_write_size_2DC};
      for (int k = 0; k < 4; k++) begin
         if ((3'(k) >= st_off) && (3'(k) < st_off + st_len)) begin
            shifted = data_write_2DC >> {st_off + st_len - 3'd1 - 3'(k), 3'b000};
            merged_word[(31 - 8*k) -: 8] = shifted[7:0];
         end
      end
   end

   always_comb begin
      state_d             = state_q;
      valid_d             = valid_q;
      dirty_d             = dirty_q;
      tag_d               = tag_q;
      data_d              = data_q;
      miss_line_d         = miss_line_q;
      scan_idx_d          = scan_idx_q;
      scan_done_d         = scan_done_q;
      data_read_fDC       = '0;
      data_valid_fDC      = 1'b0;
      flush_done          = 1'b0;
      data_address_2DM    = '0;
      MemWrite_2DM        = 1'b0;
      data_write_2DM      = '0;
      data_write_size_2DM = '0;
      dBlkRead            = 1'b0;
      dBlkWrite           = 1'b0;
      block_write_2DM     = '0;

      case (state_q)
         IDLE: begin
            if (flush_2DC) begin
               state_d     = FL_SCAN;
               scan_idx_d  = '0;
               scan_done_d = 1'b0;
            end else if (read_2DC || write_2DC) begin
               if (req_hit) begin
                  data_valid_fDC = 1'b1;
                  if (read_2DC) begin
                     data_read_fDC = hit_word;
                  end else begin
                     data_d[req_idx][{data_address_2DC[4:2], 5'b00000} +: 32] = merged_word;
                     dirty_d[req_idx] = 1'b1;
                  end
               end else if (write_2DC && !WRITE_ALLOC) begin
                  MemWrite_2DM        = 1'b1;
                  data_address_2DM    = data_address_2DC;
                  data_write_2DM      = data_write_2DC;
                  data_write_size_2DM = data_write_size_2DC;
                  data_valid_fDC      = 1'b1;
               end else begin
                  miss_line_d = data_address_2DC[31:5];
                  state_d     = (valid_q[req_idx] && dirty_q[req_idx]) ? WB : REFILL;
               end
            end
         end

         WB: begin
            dBlkWrite        = 1'b1;
            block_write_2DM  = data_q[miss_idx];
            data_address_2DM = {tag_q[miss_idx], miss_idx, 5'b00000};
            if (block_write_fDM_valid) begin
               state_d = REFILL;
            end
         end

         REFILL: begin
            dBlkRead         = 1'b1;
            data_address_2DM = {miss_line_q, 5'b00000};
            if (block_read_fDM_valid) begin
               data_d[miss_idx]  = block_read_fDM;
               tag_d[miss_idx]   = miss_tag;
               valid_d[miss_idx] = 1'b1;
               dirty_d[miss_idx] = 1'b0;
               state_d           = IDLE;
            end
         end

         FL_SCAN: begin
            if (scan_done_q) begin
               flush_done = flush_2DC;
               if (!flush_2DC) begin
                  state_d     = IDLE;
                  scan_done_d = 1'b0;
               end
            end else if (valid_q[scan_idx_q] && dirty_q[scan_idx_q]) begin
               state_d = FL_WB;
            end else begin
               valid_d[scan_idx_q] = 1'b0;
               dirty_d[scan_idx_q] = 1'b0;
               scan_idx_d          = scan_idx_q + 1'b1;
               if (scan_idx_q == IDX_W'(LINES - 1)) begin
                  scan_done_d = 1'b1;
               end
            end
         end

         FL_WB: begin
            dBlkWrite        = 1'b1;
            block_write_2DM  = data_q[scan_idx_q];
            data_address_2DM = {tag_q[scan_idx_q], scan_idx_q, 5'b00000};
            // Clearing dirty lets the rescan of this index invalidate and move on.
            if (block_write_fDM_valid) begin
               dirty_d[scan_idx_q] = 1'b0;
               state_d             = FL_SCAN;
            end
         end

         default: state_d = IDLE;
      endcase

      if (RESET) begin
         data_read_fDC       = '0;
         data_valid_fDC      = 1'b0;
         flush_done          = 1'b0;
         data_address_2DM    = '0;
         MemWrite_2DM        = 1'b0;
         data_write_2DM      = '0;
         data_write_size_2DM = '0;
         dBlkRead            = 1'b0;
         dBlkWrite           = 1'b0;
         block_write_2DM     = '0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= IDLE;
         valid_q     <= '0;
         dirty_q     <= '0;
         miss_line_q <= '0;
         scan_idx_q  <= '0;
         scan_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         valid_q     <= valid_d;
         dirty_q     <= dirty_d;
         miss_line_q <= miss_line_d;
         scan_idx_q  <= scan_idx_d;
         scan_done_q <= scan_done_d;
      end
   end

   // Line storage carries no reset; validity alone decides whether it is used.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         tag_q  <= tag_d;
         data_q <= data_d;
      end
   end

endmodule

// File: tb/tb_dcache_dm.sv
// Directed self-checking bench for dcache_dm (LINES=32) with a hand-driven block memory.

module tb_dcache_dm;

   logic         CLK = 1'b0;
   logic         RESET;
   logic [31:0]  data_address_2DC;
   logic         read_2DC, write_2DC, flush_2DC;
   logic [31:0]  data_write_2DC;
   logic [1:0]   data_write_size_2DC;
   logic [31:0]  data_read_fDC, data_address_2DM, data_write_2DM;
   logic         data_valid_fDC, flush_done, MemWrite_2DM, MemRead_2DM;
   logic [1:0]   data_write_size_2DM;
   logic         dBlkRead, dBlkWrite;
   logic [255:0] block_read_fDM, block_write_2DM;
   logic         block_read_fDM_valid, block_write_fDM_valid;

   int pass_cnt  = 0;
   int total_cnt = 0;
   logic [255:0] blk_a, blk_b, blk_c, exp_blk, exp_fl0, exp_fl1;

   always #5 CLK = ~CLK;

   dcache_dm #(.LINES(32)) dut (
      .CLK                   (CLK),
      .RESET                 (RESET),
      .data_address_2DC      (data_address_2DC),
      .read_2DC              (read_2DC),
      .write_2DC             (write_2DC),
      .data_write_2DC        (data_write_2DC),
      .data_write_size_2DC   (data_write_size_2DC),
      .flush_2DC             (flush_2DC),
      .data_read_fDC         (data_read_fDC),
      .data_valid_fDC        (data_valid_fDC),
      .flush_done            (flush_done),
      .data_address_2DM      (data_address_2DM),
      .MemWrite_2DM          (MemWrite_2DM),
      .data_write_2DM        (data_write_2DM),
      .data_write_size_2DM   (data_write_size_2DM),
      .MemRead_2DM           (MemRead_2DM),
      .dBlkRead              (dBlkRead),
      .block_read_fDM        (block_read_fDM),
      .block_read_fDM_valid  (block_read_fDM_valid),
      .dBlkWrite             (dBlkWrite),
      .block_write_2DM       (block_write_2DM),
      .block_write_fDM_valid (block_write_fDM_valid)
   );

   function automatic logic [255:0] make_blk(input logic [15:0] hi);
      logic [255:0] b;
      for (int w = 0; w < 8; w++) b[32*w +: 32] = {hi, 16'(w)};
      return b;
   endfunction

   task automatic next_cycle();
      @(negedge CLK);
   endtask

   task automatic do_read(input logic [31:0] a);
      read_2DC = 1'b1; write_2DC = 1'b0; data_address_2DC = a;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
      read_2DC = 1'b0; write_2DC = 1'b1; data_address_2DC = a;
      data_write_2DC = d; data_write_size_2DC = s;
   endtask

   task automatic no_req();
      read_2DC = 1'b0; write_2DC = 1'b0;
   endtask

   task automatic test_reset();
      RESET = 1'b1; no_req(); flush_2DC = 1'b0; data_address_2DC = '0;
      data_write_2DC = '0; data_write_size_2DC = '0; block_read_fDM = '0;
      block_read_fDM_valid = 1'b0; block_write_fDM_valid = 1'b0;
      next_cycle(); next_cycle();
      RESET = 1'b0; #1;
      total_cnt++; if (data_valid_fDC !== 1'b0) $display("[TB] FAIL reset_valid: got %b want 0", data_valid_fDC); else pass_cnt++;
      total_cnt++; if (dBlkRead !== 1'b0) $display("[TB] FAIL reset_blkread: got %b want 0", dBlkRead); else pass_cnt++;
      total_cnt++; if (dBlkWrite !== 1'b0) $display("[TB] FAIL reset_blkwrite: got %b want 0", dBlkWrite); else pass_cnt++;
      total_cnt++; if (MemWrite_2DM !== 1'b0) $display("[TB] FAIL reset_memwrite: got %b want 0", MemWrite_2DM); else pass_cnt++;
      total_cnt++; if (MemRead_2DM !== 1'b0) $display("[TB] FAIL reset_memread: got %b want 0", MemRead_2DM); else pass_cnt++;
      total_cnt++; if (flush_done !== 1'b0) $display("[TB] FAIL reset_flushdone: got %b want 0", flush_done); else pass_cnt++;
      total_cnt++; if (data_read_fDC !== 32'h0) $display("[TB] FAIL reset_rdata: got %h want 0", data_read_fDC); else pass_cnt++;
      total_cnt++; if (data_address_2DM !== 32'h0) $display("[TB] FAIL reset_memaddr: got %h want 0", data_address_2DM); else pass_cnt++;
      next_cycle();
   endtask

   task automatic test_refill();
      do_read(32'h100); #1;
      total_cnt++; if (data_valid_fDC !== 1'b0) $display("[TB] FAIL miss_valid: got %b want 0", data_valid_fDC); else pass_cnt++;
      next_cycle(); #1;
      total_cnt++; if (dBlkRead !== 1'b1) $display("[TB] FAIL refill_req: got %b want 1", dBlkRead); else pass_cnt++;
      total_cnt++; if (data_address_2DM !== 32'h100) $display("[TB] FAIL refill_addr: got %h want 00000100", data_address_2DM); else pass_cnt++;
      next_cycle(); next_cycle();
      block_read_fDM = blk_a; block_read_fDM_valid = 1'b1; #1;
      total_cnt++; if (dBlkRead !== 1'b1) $display("[TB] FAIL refill_hold: got %b want 1", dBlkRead); else pass_cnt++;
      next_cycle(); block_read_fDM_valid = 1'b0; #1;
      total_cnt++; if (data_valid_fDC !== 1'b1) $display("[TB] FAIL refill_done_valid: got %b want 1", data_valid_fDC); else pass_cnt++;
      total_cnt++; if (data_read_fDC !== 32'hDEADBEEF) $display("[TB] FAIL refill_data: got %h want DEADBEEF", data_read_fDC); else pass_cnt++;
      total_cnt++; if (dBlkRead !== 1'b0) $display("[TB] FAIL refill_drop: got %b want 0", dBlkRead); else pass_cnt++;
      next_cycle(); do_read(32'h104); #1;
      total_cnt++; if (data_valid_fDC !== 1'b1 || data_read_fDC !== 32'hC0DE0001) $display("[TB] FAIL repeat_hit: got %b/%h want 1/C0DE0001", data_valid_fDC, data_read_fDC); else pass_cnt++;
      next_cycle(); no_req();
   endtask

   task automatic test_store_hit();
      do_write(32'h100, 32'h11223344, 2'd0); #1;
      total_cnt++; if (data_valid_fDC !== 1'b1 || MemWrite_2DM !== 1'b0) $display("[TB] FAIL store_hit_word: got valid %b memwrite %b want 1/0", data_valid_fDC, MemWrite_2DM); else pass_cnt++;
      next_cycle(); do_write(32'h102, 32'hFFFFFFAA, 2'd1); #1;
      total_cnt++; if (data_valid_fDC !== 1'b1) $display("[TB] FAIL store_hit_byte: got %b want 1", data_valid_fDC); else pass_cnt++;
      next_cycle(); do_write(32'h104, 32'h1234BBCC, 2'd2);
      next_cycle(); do_write(32'h109, 32'hFF123456, 2'd3);
      next_cycle(); do_read(32'h100); #1;
      total_cnt++; if (data_read_fDC !== 32'h1122AA44) $display("[TB] FAIL merge_byte: got %h want 1122AA44", data_read_fDC); else pass_cnt++;
      next_cycle(); do_read(32'h104); #1;
      total_cnt++; if (data_read_fDC !== 32'hBBCC0001) $display("[TB] FAIL merge_half: got %h want BBCC0001", data_read_fDC); else pass_cnt++;
      next_cycle(); do_read(32'h108); #1;
      total_cnt++; if (data_read_fDC !== 32'hC0123456) $display("[TB] FAIL merge_three: got %h want C0123456", data_read_fDC); else pass_cnt++;
      next_cycle(); no_req();
   endtask

   task automatic test_writeback();
      exp_blk = blk_a;
      exp_blk[31:0] = 32'h1122AA44; exp_blk[63:32] = 32'hBBCC0001; exp_blk[95:64] = 32'hC0123456;
      do_read(32'h500); #1;
      total_cnt++; if (data_valid_fDC !== 1'b0) $display("[TB] FAIL wb_miss_valid: got %b want 0", data_valid_fDC); else pass_cnt++;
      next_cycle(); #1;
      total_cnt++; if (dBlkWrite !== 1'b1 || dBlkRead !== 1'b0) $display("[TB] FAIL wb_req: got wr %b rd %b want 1/0", dBlkWrite, dBlkRead); else pass_cnt++;
      total_cnt++; if (data_address_2DM !== 32'h100) $display("[TB] FAIL wb_addr: got %h want 00000100", data_address_2DM); else pass_cnt++;
      total_cnt++; if (block_write_2DM !== exp_blk) $display("[TB] FAIL wb_data: got %h want %h", block_write_2DM, exp_blk); else pass_cnt++;
      next_cycle(); block_write_fDM_valid = 1'b1; #1;
      total_cnt++; if (dBlkWrite !== 1'b1) $display("[TB] FAIL wb_hold: got %b want 1", dBlkWrite); else pass_cnt++;
      next_cycle(); block_write_fDM_valid = 1'b0; #1;
      total_cnt++; if (dBlkWrite !== 1'b0 || dBlkRead !== 1'b1 || data_address_2DM !== 32'h500) $display("[TB] FAIL wb_then_refill: got wr %b rd %b addr %h want 0/1/00000500", dBlkWrite, dBlkRead, data_address_2DM); else pass_cnt++;
      block_read_fDM = blk_b; block_read_fDM_valid = 1'b1;
      next_cycle(); block_read_fDM_valid = 1'b0; #1;
      total_cnt++; if (data_valid_fDC !== 1'b1 || data_read_fDC !== 32'h55550000) $display("[TB] FAIL wb_load_done: got %b/%h want 1/55550000", data_valid_fDC, data_read_fDC); else pass_cnt++;
      next_cycle(); do_read(32'h100);
      next_cycle(); #1;
      total_cnt++; if (dBlkWrite !== 1'b0 || dBlkRead !== 1'b1 || data_address_2DM !== 32'h100) $display("[TB] FAIL clean_victim: got wr %b rd %b addr %h want 0/1/00000100", dBlkWrite, dBlkRead, data_address_2DM); else pass_cnt++;
      block_read_fDM = blk_a; block_read_fDM_valid = 1'b1;
      next_cycle(); block_read_fDM_valid = 1'b0; #1;
      total_cnt++; if (data_read_fDC !== 32'hDEADBEEF) $display("[TB] FAIL clean_reload: got %h want DEADBEEF", data_read_fDC); else pass_cnt++;
      next_cycle(); no_req();
   endtask

   task automatic test_store_miss();
      do_write(32'h2000, 32'hCAFEF00D, 2'd0); #1;
`ifdef DCACHE_WRITE_ALLOCATE_EN
      total_cnt++; if (data_valid_fDC !== 1'b0 || MemWrite_2DM !== 1'b0) $display("[TB] FAIL alloc_miss: got valid %b memwrite %b want 0/0", data_valid_fDC, MemWrite_2DM); else pass_cnt++;
      next_cycle(); #1;
      total_cnt++; if (dBlkRead !== 1'b1 || data_address_2DM !== 32'h2000) $display("[TB] FAIL alloc_refill: got %b/%h want 1/00002000", dBlkRead, data_address_2DM); else pass_cnt++;
      block_read_fDM = blk_c; block_read_fDM_valid = 1'b1;
      next_cycle(); block_read_fDM_valid = 1'b0; #1;
      total_cnt++; if (data_valid_fDC !== 1'b1) $display("[TB] FAIL alloc_store_hit: got %b want 1", data_valid_fDC); else pass_cnt++;
`else
      total_cnt++; if (MemWrite_2DM !== 1'b1 || data_valid_fDC !== 1'b1) $display("[TB] FAIL wt_strobe: got memwrite %b valid %b want 1/1", MemWrite_2DM, data_valid_fDC); else pass_cnt++;
      total_cnt++; if (data_address_2DM !== 32'h2000 || data_write_2DM !== 32'hCAFEF00D || data_write_size_2DM !== 2'd0) $display("[TB] FAIL wt_pass: got %h/%h/%0d want 00002000/CAFEF00D/0", data_address_2DM, data_write_2DM, data_write_size_2DM); else pass_cnt++;
      total_cnt++; if (dBlkRead !== 1'b0) $display("[TB] FAIL wt_no_refill: got %b want 0", dBlkRead); else pass_cnt++;
      next_cycle(); do_read(32'h2000); #1;
      total_cnt++; if (data_valid_fDC !== 1'b0) $display("[TB] FAIL wt_load_misses: got %b want 0", data_valid_fDC); else pass_cnt++;
      next_cycle(); #1;
      total_cnt++; if (dBlkRead !== 1'b1 || data_address_2DM !== 32'h2000) $display("[TB] FAIL wt_load_refill: got %b/%h want 1/00002000", dBlkRead, data_address_2DM); else pass_cnt++;
      block_read_fDM = blk_c; block_read_fDM_valid = 1'b1;
      next_cycle(); block_read_fDM_valid = 1'b0; #1;
      total_cnt++; if (data_read_fDC !== 32'h77770000) $display("[TB] FAIL wt_load_data: got %h want 77770000", data_read_fDC); else pass_cnt++;
`endif
      next_cycle(); do_write(32'h2000, 32'h0BADCAFE, 2'd0); #1;
      total_cnt++; if (data_valid_fDC !== 1'b1) $display("[TB] FAIL store_after_fill: got %b want 1", data_valid_fDC); else pass_cnt++;
      next_cycle(); no_req();
   endtask

   task automatic test_flush();
      logic [31:0]  hs_addr [4];
      logic [255:0] hs_blk  [4];
      int hs = 0;
      bit done = 1'b0;
      exp_fl0 = blk_c; exp_fl0[31:0] = 32'h0BADCAFE;
      exp_fl1 = blk_a; exp_fl1[31:0] = 32'h5A5A5A5A;
      do_write(32'h100, 32'h5A5A5A5A, 2'd0);
      next_cycle(); no_req(); flush_2DC = 1'b1;
      for (int i = 0; i < 200 && !done; i++) begin
         block_write_fDM_valid = 1'b0; #1;
         if (flush_done) begin
            done = 1'b1;
         end else if (dBlkWrite) begin
            if (hs < 4) begin hs_addr[hs] = data_address_2DM; hs_blk[hs] = block_write_2DM; end
            hs++;
            block_write_fDM_valid = 1'b1;
         end
         next_cycle();
      end
      block_write_fDM_valid = 1'b0;
      total_cnt++; if (done !== 1'b1) $display("[TB] FAIL flush_done_timeout: got %b want 1", done); else pass_cnt++;
      total_cnt++; if (hs != 2) $display("[TB] FAIL flush_hs_count: got %0d want 2", hs); else pass_cnt++;
      total_cnt++; if (hs_addr[0] !== 32'h2000 || hs_blk[0] !== exp_fl0) $display("[TB] FAIL flush_wb0: got %h/%h want 00002000/%h", hs_addr[0], hs_blk[0], exp_fl0); else pass_cnt++;
      total_cnt++; if (hs_addr[1] !== 32'h100 || hs_blk[1] !== exp_fl1) $display("[TB] FAIL flush_wb1: got %h/%h want 00000100/%h", hs_addr[1], hs_blk[1], exp_fl1); else pass_cnt++;
      flush_2DC = 1'b0; #1;
      total_cnt++; if (flush_done !== 1'b0) $display("[TB] FAIL flush_done_drop: got %b want 0", flush_done); else pass_cnt++;
      next_cycle(); do_read(32'h100); #1;
      total_cnt++; if (data_valid_fDC !== 1'b0) $display("[TB] FAIL post_flush_miss: got %b want 0", data_valid_fDC); else pass_cnt++;
      next_cycle(); #1;
      total_cnt++; if (dBlkWrite !== 1'b0 || dBlkRead !== 1'b1) $display("[TB] FAIL post_flush_refill: got wr %b rd %b want 0/1", dBlkWrite, dBlkRead); else pass_cnt++;
      block_read_fDM = blk_a; block_read_fDM_valid = 1'b1;
      next_cycle(); block_read_fDM_valid = 1'b0;
      next_cycle(); do_read(32'h2000); #1;
      total_cnt++; if (data_valid_fDC !== 1'b0) $display("[TB] FAIL post_flush_miss2: got %b want 0", data_valid_fDC); else pass_cnt++;
      next_cycle(); block_read_fDM = blk_c; block_read_fDM_valid = 1'b1;
      next_cycle(); block_read_fDM_valid = 1'b0;
      next_cycle(); no_req();
   endtask

   task automatic test_reset_mid_refill();
      do_read(32'h300); #1;
      total_cnt++; if (data_valid_fDC !== 1'b0) $display("[TB] FAIL rst_pre_miss: got %b want 0", data_valid_fDC); else pass_cnt++;
      next_cycle(); #1;
      total_cnt++; if (dBlkRead !== 1'b1) $display("[TB] FAIL rst_pre_refill: got %b want 1", dBlkRead); else pass_cnt++;
      next_cycle(); RESET = 1'b1; #1;
      total_cnt++; if (dBlkRead !== 1'b0) $display("[TB] FAIL rst_abandon: got %b want 0", dBlkRead); else pass_cnt++;
      next_cycle(); RESET = 1'b0; no_req();
      block_read_fDM = blk_b; block_read_fDM_valid = 1'b1; #1;
      total_cnt++; if (dBlkRead !== 1'b0 || data_valid_fDC !== 1'b0) $display("[TB] FAIL rst_idle: got rd %b valid %b want 0/0", dBlkRead, data_valid_fDC); else pass_cnt++;
      next_cycle(); block_read_fDM_valid = 1'b0; do_read(32'h300); #1;
      total_cnt++; if (data_valid_fDC !== 1'b0) $display("[TB] FAIL rst_not_installed: got %b want 0", data_valid_fDC); else pass_cnt++;
      next_cycle(); #1;
      total_cnt++; if (dBlkRead !== 1'b1 || data_address_2DM !== 32'h300) $display("[TB] FAIL rst_refill_again: got %b/%h want 1/00000300", dBlkRead, data_address_2DM); else pass_cnt++;
      block_read_fDM_valid = 1'b1;
      next_cycle(); block_read_fDM_valid = 1'b0; #1;
      total_cnt++; if (data_valid_fDC !== 1'b1 || data_read_fDC !== 32'h55550000) $display("[TB] FAIL rst_reload: got %b/%h want 1/55550000", data_valid_fDC, data_read_fDC); else pass_cnt++;
      next_cycle(); do_read(32'h100); #1;
      total_cnt++; if (data_valid_fDC !== 1'b0) $display("[TB] FAIL rst_all_invalid: got %b want 0", data_valid_fDC); else pass_cnt++;
      next_cycle(); block_read_fDM = blk_a; block_read_fDM_valid = 1'b1;
      next_cycle(); block_read_fDM_valid = 1'b0; no_req();
      next_cycle();
   endtask

   initial begin
      blk_a = make_blk(16'hC0DE); blk_a[31:0] = 32'hDEADBEEF;
      blk_b = make_blk(16'h5555);
      blk_c = make_blk(16'h7777);
      test_reset();
      test_refill();
      test_store_hit();
      test_writeback();
      test_store_miss();
      test_flush();
      test_reset_mid_refill();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
